cpu_control_fsm: RTL and testbench



---
 rtl/cpu_ctrl_pkg.sv | 44 ++++
 rtl/cpu_control_fsm_instr_decode.sv | 47 ++++
 rtl/cpu_control_fsm.sv | 153 +++++++++++++++
 tb/tb_cpu_control_fsm.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Shared opcode/state encodings and instruction field
//                positions for the CPU control sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    // Architectural opcodes; any other 4-bit value is illegal
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_MOVI = 4'h1,
        OP_LDR  = 4'h2,
        OP_STR  = 4'h3,
        OP_JMP  = 4'h4,
        OP_HALT = 4'hF
    } opcode_e;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        DECODE   = 3'd2,
        EXEC     = 3'd3,
        MEM_WAIT = 3'd4,
        WB       = 3'd5,
        HALT     = 3'd6
    } state_e;

    // Instruction word field positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 24;
    localparam int RSV_MSB = 23;
    localparam int RSV_LSB = 20;
    localparam int IMM_W   = 20;

    // Wait counter width: enough for a memory latency of up to 7 cycles
    localparam int CNT_W   = 3;

endpackage : cpu_ctrl_pkg
`default_nettype wire

// File: rtl/cpu_control_fsm_instr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decode
//  Description : Combinational instruction field splitter and opcode
//                classifier. Undefined opcodes are reported as HALT with
//                the illegal flag raised.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output opcode_e     opc,
    output logic [3:0]  rd,
    output logic [31:0] imm,
    output logic        illegal
);

    logic [3:0] w_opc_bits;
    logic       w_unused_rsv;

    assign w_opc_bits   = ir[OPC_MSB:OPC_LSB];
    assign rd           = ir[RD_MSB:RD_LSB];
    assign imm          = {{(32-IMM_W){1'b0}}, ir[IMM_W-1:0]};
    // Reserved field carries no meaning; fold it away explicitly
    assign w_unused_rsv = ^ir[RSV_MSB:RSV_LSB];

    // Classify the opcode; unknown encodings are forced to HALT + illegal
    always_comb begin
        opc     = OP_NOP;
        illegal = 1'b0;
        case (w_opc_bits)
            4'h0:    opc = OP_NOP;
            4'h1:    opc = OP_MOVI;
            4'h2:    opc = OP_LDR;
            4'h3:    opc = OP_STR;
            4'h4:    opc = OP_JMP;
            4'hF:    opc = OP_HALT;
            default: begin
                opc     = OP_HALT;
                illegal = 1'b1;
            end
        endcase
    end

endmodule : instr_decode
`default_nettype wire

// File: rtl/cpu_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_control_fsm
//  Description : Multi-cycle fetch/decode/execute sequencer driving the
//                datapath load/store/register-write strobes. Holds the PC,
//                the instruction register and the memory latency counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0,
    parameter int MEM_LAT  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            instr_req,
    output logic [PC_W-1:0] instr_addr,
    input  logic            instr_ack,
    input  logic [31:0]     instr_rdata,
    output logic            ldr,
    output logic            str,
    output logic [31:0]     ram_address,
    output logic            reg_write_enable,
    output logic [3:0]      reg_sel,
    output logic [31:0]     immediate,
    output logic            busy,
    output logic            halted,
    output logic            illegal
);

    state_e             r_state;
    state_e             w_next_state;
    logic [PC_W-1:0]    r_pc;
    logic [31:0]        r_ir;
    logic [CNT_W-1:0]   r_cnt;

    opcode_e            w_opc;
    logic [3:0]         w_rd;
    logic [31:0]        w_imm;
    logic               w_illegal;

    instr_decode u_decode (
        .ir      (r_ir),
        .opc     (w_opc),
        .rd      (w_rd),
        .imm     (w_imm),
        .illegal (w_illegal)
    );

    assign instr_req  = (r_state == FETCH);
    assign instr_addr = r_pc;
    assign busy       = (r_state != IDLE) && (r_state != HALT);
    assign halted     = (r_state == HALT);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and Moore strobes; at most one strobe per state
    always_comb begin
        w_next_state     = r_state;
        ldr              = 1'b0;
        str              = 1'b0;
        reg_write_enable = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next_state = FETCH;
            end
            FETCH: begin
                if (instr_ack) w_next_state = DECODE;
            end
            DECODE: begin
                if (w_illegal || (w_opc == OP_HALT)) begin
                    w_next_state = HALT;
                end else if ((w_opc == OP_NOP) || (w_opc == OP_JMP)) begin
                    w_next_state = FETCH;
                end else begin
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                w_next_state = FETCH;
                case (w_opc)
                    OP_MOVI: reg_write_enable = 1'b1;
                    OP_STR:  str = 1'b1;
                    OP_LDR: begin
                        ldr          = 1'b1;
                        w_next_state = MEM_WAIT;
                    end
                    default: ;
                endcase
            end
            MEM_WAIT: begin
                if (r_cnt <= CNT_W'(1)) w_next_state = WB;
            end
            WB: begin
                reg_write_enable = 1'b1;
                w_next_state     = FETCH;
            end
            HALT: begin
                w_next_state = HALT;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // PC, IR, latency counter and the operand registers held for the datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= PC_W'(RESET_PC);
            r_ir        <= '0;
            r_cnt       <= '0;
            reg_sel     <= '0;
            immediate   <= '0;
            ram_address <= '0;
            illegal     <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (instr_ack) begin
                        r_ir <= instr_rdata;
                        r_pc <= r_pc + 1'b1;
                    end
                end
                DECODE: begin
                    reg_sel     <= w_rd;
                    immediate   <= w_imm;
                    ram_address <= w_imm;
                    // Jump target replaces the increment done during fetch
                    if (!w_illegal && (w_opc == OP_JMP)) r_pc <= w_imm[PC_W-1:0];
                    if (w_illegal) illegal <= 1'b1;
                end
                EXEC: begin
                    if (w_opc == OP_LDR) r_cnt <= CNT_W'(MEM_LAT);
                end
                MEM_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule : cpu_control_fsm
`default_nettype wire

// File: tb/tb_cpu_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_control_fsm
//  Description : Scoreboard bench for cpu_control_fsm. Directed instruction
//                sequences push expected strobes; a monitor pops and checks
//                every strobe the DUT presents, including its cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_control_fsm;

    localparam int PC_W    = 8;
    localparam int MEM_LAT = 3;

    localparam logic [2:0] K_LDR = 3'b100;
    localparam logic [2:0] K_STR = 3'b010;
    localparam logic [2:0] K_RWE = 3'b001;

    typedef struct {
        logic [2:0]  kind;
        logic [3:0]  sel;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            instr_req;
    logic [PC_W-1:0] instr_addr;
    logic            instr_ack = 1'b0;
    logic [31:0]     instr_rdata = '0;
    logic            ldr;
    logic            str;
    logic [31:0]     ram_address;
    logic            reg_write_enable;
    logic [3:0]      reg_sel;
    logic [31:0]     immediate;
    logic            busy;
    logic            halted;
    logic            illegal;

    int              n_checks = 0;
    int              n_fail   = 0;
    int              cyc      = 0;
    logic [PC_W-1:0] exp_pc   = '0;
    exp_t            sb[$];

    cpu_control_fsm #(
        .PC_W     (PC_W),
        .RESET_PC (0),
        .MEM_LAT  (MEM_LAT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .instr_req        (instr_req),
        .instr_addr       (instr_addr),
        .instr_ack        (instr_ack),
        .instr_rdata      (instr_rdata),
        .ldr              (ldr),
        .str              (str),
        .ram_address      (ram_address),
        .reg_write_enable (reg_write_enable),
        .reg_sel          (reg_sel),
        .immediate        (immediate),
        .busy             (busy),
        .halted           (halted),
        .illegal          (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [2:0] kind, input logic [3:0] sel,
                        input logic [31:0] val, input int c);
        exp_t e;
        e.kind = kind;
        e.sel  = sel;
        e.val  = val;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve one fetch with dly wait cycles; checks req/addr hold every cycle
    task automatic fetch(input logic [31:0] instr, input int dly, output int ack_cyc);
        int guard = 0;
        while (!instr_req && guard < 50) begin
            tick();
            guard++;
        end
        check("fetch_req", 32'(instr_req), 32'd1);
        check("fetch_addr", 32'(instr_addr), 32'(exp_pc));
        for (int i = 0; i < dly; i++) begin
            tick();
            check("req_hold", 32'(instr_req), 32'd1);
            check("addr_hold", 32'(instr_addr), 32'(exp_pc));
        end
        instr_ack   = 1'b1;
        instr_rdata = instr;
        ack_cyc     = cyc;
        tick();
        instr_ack   = 1'b0;
        instr_rdata = '0;
        exp_pc      = exp_pc + 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        int   nstb;
        exp_t e;
        if (!rst) begin
            nstb = int'(ldr) + int'(str) + int'(reg_write_enable);
            if (nstb > 1) begin
                n_checks++;
                n_fail++;
                $display("FAIL one_strobe: got %0d strobes expected 1 (cycle %0d)", nstb, cyc);
            end
            if (nstb != 0) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got {ldr,str,rwe}=%b expected none (cycle %0d)",
                             {ldr, str, reg_write_enable}, cyc);
                end else begin
                    e = sb.pop_front();
                    check("strobe_kind", 32'({ldr, str, reg_write_enable}), 32'(e.kind));
                    check("strobe_cycle", 32'(cyc), 32'(e.cyc));
                    check("strobe_reg_sel", 32'(reg_sel), 32'(e.sel));
                    if (reg_write_enable) check("strobe_immediate", immediate, e.val);
                    else                  check("strobe_ram_address", ram_address, e.val);
                end
            end
        end
    end

    initial begin
        int a;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_req", 32'(instr_req), 32'd0);
        check("rst_addr", 32'(instr_addr), 32'd0);
        check("rst_reg_sel", 32'(reg_sel), 32'd0);
        check("rst_immediate", immediate, 32'd0);
        check("rst_ram_address", ram_address, 32'd0);
        tick();
        check("idle_hold", 32'(busy), 32'd0);

        // MOVI r3, 0xABC zero-wait
        pulse_start();
        fetch(32'h1300_0ABC, 0, a);
        push(K_RWE, 4'd3, 32'h0000_0ABC, a + 2);

        // LDR r5, 0x10: ldr at ack+2, write-back MEM_LAT+1 later
        fetch(32'h2500_0010, 0, a);
        push(K_LDR, 4'd5, 32'h0000_0010, a + 2);
        push(K_RWE, 4'd5, 32'h0000_0010, a + 2 + MEM_LAT + 1);

        // STR r2, 0x20 with three wait cycles on the fetch
        fetch(32'h3200_0020, 3, a);
        push(K_STR, 4'd2, 32'h0000_0020, a + 2);

        // JMP 0xFF, NOP at 0xFF wraps to 0, JMP 0x1FF truncates to 0xFF
        fetch(32'h4000_00FF, 0, a);
        exp_pc = 8'hFF;
        fetch(32'h0000_0000, 0, a);
        check("pc_wrap", 32'(exp_pc), 32'd0);
        fetch(32'h4000_01FF, 0, a);
        exp_pc = 8'hFF;

        // Illegal opcode 0x7
        fetch(32'h7000_0000, 0, a);
        check("decode_not_halted", 32'(halted), 32'd0);
        check("decode_busy", 32'(busy), 32'd1);
        tick();
        check("ill_illegal", 32'(illegal), 32'd1);
        check("ill_halted", 32'(halted), 32'd1);
        check("ill_busy", 32'(busy), 32'd0);
        pulse_start();
        pulse_start();
        check("halt_ignores_start", 32'(halted), 32'd1);
        check("halt_no_req", 32'(instr_req), 32'd0);
        check("halt_illegal_sticky", 32'(illegal), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_pc = '0;
        check("clr_illegal", 32'(illegal), 32'd0);
        check("clr_halted", 32'(halted), 32'd0);
        check("clr_pc", 32'(instr_addr), 32'd0);

        // LDR aborted by reset during MEM_WAIT: no write-back may follow
        pulse_start();
        fetch(32'h2500_0010, 0, a);
        push(K_LDR, 4'd5, 32'h0000_0010, a + 2);
        while (cyc < a + 3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_req", 32'(instr_req), 32'd0);
        check("abort_strobes", 32'({ldr, str, reg_write_enable}), 32'd0);
        check("abort_reg_sel", 32'(reg_sel), 32'd0);
        check("abort_ram_address", ram_address, 32'd0);
        for (int i = 0; i < 10; i++) tick();
        check("abort_still_idle", 32'(busy), 32'd0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so a stuck DUT cannot hang the run
    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule : tb_cpu_control_fsm
`default_nettype wire
